// File: rtl/hilo_unit_if.sv
// hilo_unit_if: command/result bundle between pipeline control and the HI/LO unit.
// The master side issues commands and operands, the slave side (hilo_unit)
// returns the architectural HI/LO values and the divide busy/done handshake.
interface hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, alu_hi, alu_lo, a, b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, alu_hi, alu_lo, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair of the MIPS datapath.
// Captures multiply products, services mthi/mtlo and runs div/divu as a
// 32-iteration restoring divider with a registered busy/done handshake.
// Build option: define HILO_DIV_EN to compile in the divider; without it the
// divide ops are no-ops and busy/done are tied low.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    hilo_unit_if.slave bus
);
    localparam logic [2:0] OpLoad = 3'b001;
    localparam logic [2:0] OpMthi = 3'b010;
    localparam logic [2:0] OpMtlo = 3'b011;
    localparam logic [2:0] OpDiv  = 3'b100;
    localparam logic [2:0] OpDivu = 3'b101;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             moveHiEn, moveLoEn;
    logic [WIDTH-1:0] moveHiVal, moveLoVal;

    // Decode the single-cycle register moves (product load, mthi, mtlo)
    always_comb begin
        moveHiEn  = 1'b0;
        moveLoEn  = 1'b0;
        moveHiVal = bus.a;
        moveLoVal = bus.a;
        if (bus.start) begin
            case (bus.op)
                OpLoad: begin
                    moveHiEn  = 1'b1;
                    moveLoEn  = 1'b1;
                    moveHiVal = bus.alu_hi;
                    moveLoVal = bus.alu_lo;
                end
                OpMthi:  moveHiEn = 1'b1;
                OpMtlo:  moveLoEn = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       iterCnt_q, iterCnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             qNeg_q, qNeg_d;
    logic             rNeg_q, rNeg_d;
    logic             divZero_q, divZero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   trialDiff;
    logic             trialOk;
    logic [WIDTH-1:0] absA, absB;

    // Divider FSM: operand latch, one restoring iteration per cycle, sign fix-up
    always_comb begin
        state_d   = state_q;
        iterCnt_d = iterCnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        qNeg_d    = qNeg_q;
        rNeg_d    = rNeg_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        absA = bus.a[WIDTH-1] ? -bus.a : bus.a;
        absB = bus.b[WIDTH-1] ? -bus.b : bus.b;

        // The shifted partial remainder can carry into bit WIDTH; when it does
        // it is certainly larger than any WIDTH-bit divisor, so the trial wins
        // even though the WIDTH+1-bit difference wrapped.
        remShift  = {rem_q, quo_q[WIDTH-1]};
        trialDiff = remShift - {1'b0, divisor_q};
        trialOk   = remShift[WIDTH] | ~trialDiff[WIDTH];

        unique case (state_q)
            IDLE: begin
                if (moveHiEn) hi_d = moveHiVal;
                if (moveLoEn) lo_d = moveLoVal;
                if (bus.start && (bus.op == OpDiv || bus.op == OpDivu)) begin
                    rem_d     = '0;
                    iterCnt_d = '0;
                    divZero_d = (bus.b == '0);
                    state_d   = DIV;
                    if (bus.op == OpDiv) begin
                        quo_d     = absA;
                        divisor_d = absB;
                        qNeg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rNeg_d    = bus.a[WIDTH-1];
                    end else begin
                        quo_d     = bus.a;
                        divisor_d = bus.b;
                        qNeg_d    = 1'b0;
                        rNeg_d    = 1'b0;
                    end
                end
            end
            DIV: begin
                rem_d     = trialOk ? trialDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
                quo_d     = {quo_q[WIDTH-2:0], trialOk};
                iterCnt_d = iterCnt_q + 6'd1;
                if (iterCnt_q == 6'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                // A zero divisor leaves rem equal to |a|, so the remainder
                // fix-up already reproduces the original dividend in hi.
                lo_d    = divZero_q ? '1 : (qNeg_q ? -quo_q : quo_q);
                hi_d    = rNeg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iterCnt_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            qNeg_q    <= 1'b0;
            rNeg_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iterCnt_q <= iterCnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            qNeg_q    <= qNeg_d;
            rNeg_q    <= rNeg_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
`else
    logic unusedDivisor;

    // Without the divider only the register moves update HI/LO
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (moveHiEn) hi_d = moveHiVal;
        if (moveLoEn) lo_d = moveLoVal;
    end

    // Architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign unusedDivisor = ^bus.b;
    assign bus.busy      = 1'b0;
    assign bus.done      = 1'b0;
`endif

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit. The driver pushes the
// expected per-cycle HI/LO/busy/done into a queue from an arithmetic model;
// a monitor pops one entry after every rising edge and compares.
module tb_hilo_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

`ifdef HILO_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failures = 0;
    exp_t expQ[$];

    // Reference state: architectural values plus a pending divide result
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    int          mRemain = 0;
    logic [31:0] mResHi = '0;
    logic [31:0] mResLo = '0;

    hilo_unit_if #(.WIDTH(32)) bus ();

    hilo_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Divide as the architecture defines it, using plain integer arithmetic
    function automatic void divRef(input bit isSigned, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (isSigned) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drive one cycle of inputs and push what the outputs must be after the edge
    task automatic applyStimulus(input logic rstN, input logic st, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ah, input logic [31:0] al,
                                 input string tag);
        exp_t        e;
        logic        doneNow;
        logic [31:0] q, r;
        @(negedge clk);
        rst_n      = rstN;
        bus.start  = st;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.alu_hi = ah;
        bus.alu_lo = al;
        doneNow    = 1'b0;
        if (!rstN) begin
            mHi     = '0;
            mLo     = '0;
            mRemain = 0;
        end else if (mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
                mHi     = mResHi;
                mLo     = mResLo;
                doneNow = 1'b1;
            end
        end else if (st) begin
            case (op)
                3'b001: begin mHi = ah; mLo = al; end
                3'b010: mHi = a;
                3'b011: mLo = a;
                3'b100, 3'b101: begin
                    if (DivEn) begin
                        divRef(op == 3'b100, a, b, q, r);
                        mResLo  = q;
                        mResHi  = r;
                        mRemain = 33;
                    end
                end
                default: ;
            endcase
        end
        e.hi   = mHi;
        e.lo   = mLo;
        e.busy = (mRemain > 0);
        e.done = doneNow;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                          $urandom, $urandom, tag);
    endtask

    // Issue a divide and run it through its done cycle
    task automatic doDiv(input bit isSigned, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        applyStimulus(1'b1, 1'b1, isSigned ? 3'b100 : 3'b101, a, b, $urandom, $urandom, tag);
        idle(33, tag);
    endtask

    task automatic checkOutput(input exp_t e);
        tests++;
        if (bus.hi !== e.hi) begin
            failures++;
            $display("[TB] FAIL %s hi: got %h expected %h", e.tag, bus.hi, e.hi);
        end
        tests++;
        if (bus.lo !== e.lo) begin
            failures++;
            $display("[TB] FAIL %s lo: got %h expected %h", e.tag, bus.lo, e.lo);
        end
        tests++;
        if (bus.busy !== e.busy) begin
            failures++;
            $display("[TB] FAIL %s busy: got %b expected %b", e.tag, bus.busy, e.busy);
        end
        tests++;
        if (bus.done !== e.done) begin
            failures++;
            $display("[TB] FAIL %s done: got %b expected %b", e.tag, bus.done, e.done);
        end
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Stimulus sequence: directed scenarios followed by a random mix
    initial begin
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        bus.alu_hi = '0;
        bus.alu_lo = '0;

        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom,
                          $urandom, $urandom, "reset");

        applyStimulus(1'b1, 1'b1, 3'b001, $urandom, $urandom, 32'h0000_0001, 32'hFFFF_FFFE, "load");
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h1234_5678, $urandom, $urandom, $urandom, "mthi");
        applyStimulus(1'b1, 1'b1, 3'b011, 32'hCAFE_0001, $urandom, $urandom, $urandom, "mtlo");
        idle(2, "hold");

        doDiv(1'b0, 32'd100, 32'd7, "divu_100_7");
        doDiv(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        doDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        doDiv(1'b1, 32'd5, 32'd0, "div_by0");
        doDiv(1'b1, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
        doDiv(1'b0, 32'hFFFF_FFFF, 32'd0, "divu_by0");
        doDiv(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
        doDiv(1'b1, 32'h8000_0000, 32'd3, "div_min_3");
        idle(1, "gap");

        // A move issued mid-divide must be dropped
        applyStimulus(1'b1, 1'b1, 3'b101, 32'd1000, 32'd3, $urandom, $urandom, "collide");
        idle(4, "collide");
        applyStimulus(1'b1, 1'b1, 3'b011, 32'h0000_00AA, $urandom, $urandom, $urandom, "collide_mtlo");
        idle(28, "collide");

        // Reset in the middle of a divide aborts it
        applyStimulus(1'b1, 1'b1, 3'b100, 32'd77, 32'd5, $urandom, $urandom, "abort");
        idle(9, "abort");
        applyStimulus(1'b0, 1'b1, 3'b001, $urandom, $urandom, $urandom, $urandom, "abort_rst");
        idle(40, "after_abort");

        for (int i = 0; i < 600; i++) begin
            logic [31:0] rb;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(1'b1, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, rb,
                          $urandom, $urandom, "random");
        end
        idle(36, "drain");

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d entries pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
